mult_secuencial_booth: RTL and testbench

- Sequential signed fixed-point multiplier (radix-2 Booth) that produces the full-width 2N-bit two's-complement product consumed by the datapath truncation/saturation stage.
- Sits upstream of the truncation stage: the operand pair is captured on `start`, N Booth iterations run, then the product is presented on `Datos_Sum` with a one-cycle `done` pulse.
- Binary point is implicit: product fraction bits = FA+FB, where FA and FB are the operand fraction widths. The block performs no rounding and no truncation.

---
 rtl/mult_pkg.sv | 19 +
 rtl/booth_paso.sv | 31 +++
 rtl/mult_secuencial_booth.sv | 103 ++++++++++
 tb/tb_mult_secuencial_booth.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the Booth multiplier and the downstream truncation stage.
package mult_pkg;

  // Default operand width and fraction formats shared with the truncation stage
  localparam int unsigned N_DEF  = 25;
  localparam int unsigned FA_DEF = 14;
  localparam int unsigned FB_DEF = 19;

  // Full-width product size for the default operand width
  localparam int unsigned PROD_W = 2 * N_DEF;

  // Control states of the sequential multiplier
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage : mult_pkg

// File: rtl/booth_paso.sv
// One radix-2 Booth iteration: conditional add/subtract of M, then arithmetic right shift.
module booth_paso #(
  parameter int unsigned N = 25
) (
  input  logic [N:0]   acc,
  input  logic [N-1:0] q,
  input  logic         q_1,
  input  logic [N:0]   m,
  output logic [N:0]   acc_c,
  output logic [N-1:0] q_c,
  output logic         q_1_c
);

  logic [N:0] sum_c;

  // Booth decode on {q[0], q_1}: 01 adds M, 10 subtracts M, otherwise keep ACC
  always_comb begin
    sum_c = acc;
    case ({q[0], q_1})
      2'b01:   sum_c = acc + m;
      2'b10:   sum_c = acc - m;
      default: sum_c = acc;
    endcase
  end

  // Arithmetic right shift of {ACC, Q, q_1}; ACC sign bit is replicated
  assign acc_c = {sum_c[N], sum_c[N:1]};
  assign q_c   = {sum_c[0], q[N-1:1]};
  assign q_1_c = q[0];

endmodule : booth_paso

// File: rtl/mult_secuencial_booth.sv
// Sequential signed radix-2 Booth multiplier producing the exact 2N-bit product.
// Product binary point sits FA+FB bits from the LSB; no rounding or truncation here.
module mult_secuencial_booth
  import mult_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned FA = FA_DEF,
  parameter int unsigned FB = FB_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   Dato_A,
  input  logic [N-1:0]   Dato_B,
  output logic [2*N-1:0] Datos_Sum,
  output logic           busy,
  output logic           done
);

  localparam int unsigned PW    = 2 * N;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned FRAC  = FA + FB;

  state_t           state;
  logic [N:0]       m;
  logic [N:0]       acc;
  logic [N-1:0]     q;
  logic             q_1;
  logic [CNT_W-1:0] cnt;

  logic [N:0]       acc_c;
  logic [N-1:0]     q_c;
  logic             q_1_c;

  // Single Booth step datapath feeding the CALC state
  booth_paso #(
    .N(N)
  ) u_paso (
    .acc   (acc),
    .q     (q),
    .q_1   (q_1),
    .m     (m),
    .acc_c (acc_c),
    .q_c   (q_c),
    .q_1_c (q_1_c)
  );

  // Control FSM with datapath registers; reset clears everything and drops any pending request
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      m         <= '0;
      acc       <= '0;
      q         <= '0;
      q_1       <= 1'b0;
      cnt       <= '0;
      Datos_Sum <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m     <= {Dato_A[N-1], Dato_A};
            q     <= Dato_B;
            acc   <= '0;
            q_1   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            busy <= 1'b0;
          end
        end
        CALC: begin
          acc <= acc_c;
          q   <= q_c;
          q_1 <= q_1_c;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(N - 1)) begin
            state <= FIN;
          end
        end
        FIN: begin
          // busy stays high through the done cycle
          Datos_Sum <= PW'({acc[N-1:0], q});
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Fraction widths only describe the product format; keep them referenced
  logic unused_frac;
  assign unused_frac = ^FRAC;

endmodule : mult_secuencial_booth

// File: tb/tb_mult_secuencial_booth.sv
// Self-checking bench for mult_secuencial_booth with a product scoreboard.
module tb_mult_secuencial_booth;

  localparam int N  = 25;
  localparam int PW = 2 * N;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [N-1:0]  Dato_A;
  logic [N-1:0]  Dato_B;
  logic [PW-1:0] Datos_Sum;
  logic          busy;
  logic          done;

  mult_secuencial_booth dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .Dato_A    (Dato_A),
    .Dato_B    (Dato_B),
    .Datos_Sum (Datos_Sum),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int            tests  = 0;
  int            fails  = 0;
  int            cyc    = 0;
  int            done_cnt = 0;
  int            busy_hi  = 0;
  logic [PW-1:0] prev_sum = '0;
  logic [PW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference product through native 64-bit signed multiply
  function automatic logic [PW-1:0] model(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
    longint pa, pb;
    pa = a;
    pb = b;
    return PW'(pa * pb);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard pop on done, output hold check, busy accounting
  always @(posedge clk) begin
    #1;
    if (busy) busy_hi++;
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) check("unexpected_done", 64'(done), 64'(0));
      else check("product", 64'(Datos_Sum), 64'(exp_q.pop_front()));
    end else if (!reset) begin
      check("hold", 64'(Datos_Sum), 64'(prev_sum));
    end
    prev_sum = Datos_Sum;
  end

  task automatic wait_done(output int at_cyc);
    bit seen = 0;
    at_cyc = -1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1;
        at_cyc = cyc;
      end
    end
    if (!seen) check("done_timeout", 64'(0), 64'(1));
  endtask

  // Drive a one-cycle start, queue the expected product, return the accept cycle
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, output int acc_cyc);
    @(negedge clk);
    Dato_A = a;
    Dato_B = b;
    start  = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b);
    int k, d;
    launch(a, b, k);
    wait_done(d);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int k, d, d0, d1, d2, dc;
    logic [N-1:0] ops[3];
    reset  = 1'b1;
    start  = 1'b0;
    Dato_A = '0;
    Dato_B = '0;
    idle_cycles(3);
    check("rst_sum",  64'(Datos_Sum), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // 3 x 5 with latency/busy timing and operand changes during CALC
    busy_hi = 0;
    launch(25'd3, 25'd5, k);
    Dato_A = 25'h1ABCDEF;
    Dato_B = 25'h0123456;
    wait_done(d);
    check("latency", 64'(d - k), 64'(N + 1));
    check("sum_3x5", 64'(Datos_Sum), 64'(15));
    idle_cycles(1);
    check("busy_len", 64'(busy_hi), 64'(N + 2));
    check("busy_after", 64'(busy), 64'(0));

    // Sign and extreme operands
    run_op(25'h1FFFFFF, 25'h1FFFFFF);
    check("sum_m1m1", 64'(Datos_Sum), 64'(1));
    run_op(-25'sd7, 25'd9);
    check("sum_m7x9", 64'(Datos_Sum), 64'(50'h3FFFFFFFFFFC1));
    run_op(25'h1000000, 25'h1000000);
    check("sum_minmin", 64'(Datos_Sum), 64'(50'h1000000000000));
    run_op(25'h0FFFFFF, 25'h1000000);
    check("sum_maxmin", 64'(Datos_Sum), 64'(-(64'sd1 <<< 48) + (64'sd1 <<< 24)) & 64'h3FFFFFFFFFFFF);
    for (int i = 0; i < 6; i++) run_op(25'($urandom), 25'($urandom));

    // Start while busy is ignored
    dc = done_cnt;
    launch(25'd12, 25'd12, k);
    idle_cycles(8);
    @(negedge clk);
    Dato_A = 25'd7;
    Dato_B = 25'd7;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(d);
    check("sum_12x12", 64'(Datos_Sum), 64'(144));
    idle_cycles(40);
    check("busy_start_dones", 64'(done_cnt - dc), 64'(1));

    // Reset mid-CALC drops the operation
    dc = done_cnt;
    launch(25'd1000, 25'd1000, k);
    void'(exp_q.pop_back());
    idle_cycles(10);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_sum",  64'(Datos_Sum), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(40);
    check("midrst_nodone", 64'(done_cnt - dc), 64'(0));
    run_op(25'd2, 25'd3);
    check("sum_2x3", 64'(Datos_Sum), 64'(6));

    // Reset and start together: request dropped
    dc = done_cnt;
    @(negedge clk);
    reset  = 1'b1;
    start  = 1'b1;
    Dato_A = 25'd9;
    Dato_B = 25'd9;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    idle_cycles(40);
    check("rststart_nodone", 64'(done_cnt - dc), 64'(0));
    check("rststart_busy", 64'(busy), 64'(0));

    // Start held high: back-to-back products
    ops[0] = 25'd4;
    ops[1] = 25'd5;
    ops[2] = 25'd6;
    @(negedge clk);
    Dato_A = ops[0];
    Dato_B = ops[0];
    start  = 1'b1;
    exp_q.push_back(model(ops[0], ops[0]));
    wait_done(d0);
    check("held_16", 64'(Datos_Sum), 64'(16));
    @(negedge clk);
    Dato_A = ops[1];
    Dato_B = ops[1];
    exp_q.push_back(model(ops[1], ops[1]));
    wait_done(d1);
    check("held_25", 64'(Datos_Sum), 64'(25));
    @(negedge clk);
    Dato_A = ops[2];
    Dato_B = ops[2];
    exp_q.push_back(model(ops[2], ops[2]));
    wait_done(d2);
    check("held_36", 64'(Datos_Sum), 64'(36));
    @(negedge clk);
    start = 1'b0;
    check("held_gap1", 64'(d1 - d0), 64'(N + 2));
    check("held_gap2", 64'(d2 - d1), 64'(N + 2));
    idle_cycles(40);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_mult_secuencial_booth
